// File: rtl/hdlc_rx_deframer_if.sv
// HDLC receive deframer signal bundle: serial line in, frame status and bytes out.
interface hdlc_rx_deframer_if;
   logic       Rx;
   logic       RxEN;
   logic       Rx_FlagDetect;
   logic       Rx_AbortDetect;
   logic       Rx_ValidFrame;
   logic [7:0] Rx_Data;
   logic       Rx_NewByte;
   logic       Rx_EoF;
   logic       Rx_FrameError;
   logic [7:0] Rx_FrameSize;

   // Line driver side
   modport master (
      output Rx, RxEN,
      input  Rx_FlagDetect, Rx_AbortDetect, Rx_ValidFrame, Rx_Data, Rx_NewByte,
      input  Rx_EoF, Rx_FrameError, Rx_FrameSize
   );

   // Deframer side
   modport slave (
      input  Rx, RxEN,
      output Rx_FlagDetect, Rx_AbortDetect, Rx_ValidFrame, Rx_Data, Rx_NewByte,
      output Rx_EoF, Rx_FrameError, Rx_FrameSize
   );
endinterface

// File: rtl/hdlc_rx_deframer.sv
// HDLC receive front end: flag/abort detection on an 8-bit raw window, zero-bit
// destuffing of the bits leaving the window, LSB-first byte assembly and
// end-of-frame status with byte count.
module hdlc_rx_deframer #(
   parameter int unsigned MAX_BYTES = 128
) (
   input logic                 Clk,
   input logic                 Rst,
   hdlc_rx_deframer_if.slave   rxIf
);

   localparam logic [7:0] FlagPattern = 8'h7E;
   localparam logic [7:0] MaxBytes    = 8'(MAX_BYTES);

   typedef enum logic [1:0] {StIdle, StHunt, StFrame} state_e;

   state_e     state_q, state_d;
   logic [7:0] win_q, win_d;            // win_q[7] is the newest bit
   logic [3:0] flushCnt_q, flushCnt_d;  // exiting bits still belonging to a flag
   logic [2:0] onesCnt_q, onesCnt_d;
   logic [2:0] bitCnt_q, bitCnt_d;
   logic [6:0] shreg_q, shreg_d;
   logic [7:0] byteCnt_q, byteCnt_d;
   logic [7:0] data_q, data_d;
   logic [7:0] frameSize_q, frameSize_d;
   logic       flagDet_q, flagDet_d;
   logic       abortDet_q, abortDet_d;
   logic       newByte_q, newByte_d;
   logic       eof_q, eof_d;
   logic       frameErr_q, frameErr_d;

   logic [7:0] winNext;
   logic       bitOut;
   logic       isFlag;
   logic       isAbort;
   logic       overflow;
   logic       openFrame;

   // Next-state: window shift, destuffing, byte assembly and frame status
   always_comb begin
      state_d     = state_q;
      win_d       = win_q;
      flushCnt_d  = flushCnt_q;
      onesCnt_d   = onesCnt_q;
      bitCnt_d    = bitCnt_q;
      shreg_d     = shreg_q;
      byteCnt_d   = byteCnt_q;
      data_d      = data_q;
      frameSize_d = frameSize_q;
      flagDet_d   = 1'b0;
      abortDet_d  = 1'b0;
      newByte_d   = 1'b0;
      eof_d       = 1'b0;
      frameErr_d  = 1'b0;
      winNext     = {rxIf.Rx, win_q[7:1]};
      bitOut      = win_q[0];
      isFlag      = (winNext == FlagPattern);
      isAbort     = &winNext[7:1];
      overflow    = 1'b0;
      openFrame   = 1'b0;

      if (rxIf.RxEN) begin
         win_d = winNext;
         if (flushCnt_q != 4'd0) begin
            flushCnt_d = flushCnt_q - 4'd1;
         end
         unique case (state_q)
            StFrame: begin
               if (isAbort) begin
                  abortDet_d = 1'b1;
                  state_d    = StHunt;
                  bitCnt_d   = 3'd0;
                  byteCnt_d  = 8'd0;
                  onesCnt_d  = 3'd0;
               end else begin
                  if (flushCnt_q == 4'd0) begin
                     if (onesCnt_q == 3'd5 && !bitOut) begin
                        // stuffed zero
                        onesCnt_d = 3'd0;
                     end else begin
                        shreg_d = {bitOut, shreg_q[6:1]};
                        if (!bitOut) begin
                           onesCnt_d = 3'd0;
                        end else if (onesCnt_q != 3'd7) begin
                           onesCnt_d = onesCnt_q + 3'd1;
                        end
                        if (bitCnt_q == 3'd7) begin
                           bitCnt_d = 3'd0;
                           if (byteCnt_q == MaxBytes) begin
                              overflow = 1'b1;
                           end else begin
                              data_d    = {bitOut, shreg_q};
                              newByte_d = 1'b1;
                              byteCnt_d = byteCnt_q + 8'd1;
                           end
                        end else begin
                           bitCnt_d = bitCnt_q + 3'd1;
                        end
                     end
                  end
                  if (overflow) begin
                     frameErr_d = 1'b1;
                     state_d    = StHunt;
                     byteCnt_d  = 8'd0;
                     onesCnt_d  = 3'd0;
                  end
                  if (isFlag) begin
                     // counts here already include a byte finishing on this bit
                     if (!overflow) begin
                        if (bitCnt_d != 3'd0 || (byteCnt_d != 8'd0 && byteCnt_d < 8'd2)) begin
                           frameErr_d = 1'b1;
                        end else if (byteCnt_d != 8'd0) begin
                           eof_d       = 1'b1;
                           frameSize_d = byteCnt_d;
                        end
                     end
                     openFrame = 1'b1;
                  end
               end
            end
            default: begin
               if (isFlag) begin
                  openFrame = 1'b1;
               end
            end
         endcase
         if (openFrame) begin
            flagDet_d  = 1'b1;
            flushCnt_d = 4'd8;
            onesCnt_d  = 3'd0;
            bitCnt_d   = 3'd0;
            byteCnt_d  = 8'd0;
            state_d    = StFrame;
         end
      end
   end

   // State and output registers
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state_q     <= StIdle;
         win_q       <= 8'd0;
         flushCnt_q  <= 4'd0;
         onesCnt_q   <= 3'd0;
         bitCnt_q    <= 3'd0;
         shreg_q     <= 7'd0;
         byteCnt_q   <= 8'd0;
         data_q      <= 8'd0;
         frameSize_q <= 8'd0;
         flagDet_q   <= 1'b0;
         abortDet_q  <= 1'b0;
         newByte_q   <= 1'b0;
         eof_q       <= 1'b0;
         frameErr_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         win_q       <= win_d;
         flushCnt_q  <= flushCnt_d;
         onesCnt_q   <= onesCnt_d;
         bitCnt_q    <= bitCnt_d;
         shreg_q     <= shreg_d;
         byteCnt_q   <= byteCnt_d;
         data_q      <= data_d;
         frameSize_q <= frameSize_d;
         flagDet_q   <= flagDet_d;
         abortDet_q  <= abortDet_d;
         newByte_q   <= newByte_d;
         eof_q       <= eof_d;
         frameErr_q  <= frameErr_d;
      end
   end

   assign rxIf.Rx_FlagDetect  = flagDet_q;
   assign rxIf.Rx_AbortDetect = abortDet_q;
   assign rxIf.Rx_ValidFrame  = (state_q == StFrame);
   assign rxIf.Rx_Data        = data_q;
   assign rxIf.Rx_NewByte     = newByte_q;
   assign rxIf.Rx_EoF         = eof_q;
   assign rxIf.Rx_FrameError  = frameErr_q;
   assign rxIf.Rx_FrameSize   = frameSize_q;

endmodule

// File: tb/tb_hdlc_rx_deframer.sv
// Scoreboard bench for hdlc_rx_deframer: stimulus pushes expected pulse events,
// a negedge monitor pops and compares each pulse the DUT produces.
module tb_hdlc_rx_deframer;

   localparam int KByte  = 0;
   localparam int KFlag  = 1;
   localparam int KEof   = 2;
   localparam int KErr   = 3;
   localparam int KAbort = 4;

   typedef struct {
      int         kind;
      logic [7:0] val;
      logic       valid;
   } ev_t;

   logic Clk;
   logic Rst;
   logic gapMode;
   int   checks;
   int   errors;
   ev_t  expQ[$];

   hdlc_rx_deframer_if rxIf ();

   hdlc_rx_deframer #(.MAX_BYTES(4)) dut (
      .Clk  (Clk),
      .Rst  (Rst),
      .rxIf (rxIf)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   function automatic string kindName(input int k);
      case (k)
         KByte:   return "NewByte";
         KFlag:   return "FlagDetect";
         KEof:    return "EoF";
         KErr:    return "FrameError";
         default: return "AbortDetect";
      endcase
   endfunction

   task automatic expect_ev(input int kind, input logic [7:0] val, input logic valid);
      ev_t e;
      e.kind  = kind;
      e.val   = val;
      e.valid = valid;
      expQ.push_back(e);
   endtask

   task automatic checkEv(input int kind, input logic [7:0] val);
      ev_t e;
      checks++;
      if (expQ.size() == 0) begin
         errors++;
         $display("FAIL unexpected_%s got val=%02h valid=%0b required no event",
                  kindName(kind), val, rxIf.Rx_ValidFrame);
      end else begin
         e = expQ.pop_front();
         if (e.kind != kind || e.val !== val || e.valid !== rxIf.Rx_ValidFrame) begin
            errors++;
            $display("FAIL event got %s val=%02h valid=%0b required %s val=%02h valid=%0b",
                     kindName(kind), val, rxIf.Rx_ValidFrame, kindName(e.kind), e.val, e.valid);
         end
      end
   endtask

   task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s got %0h required %0h", name, act, req);
      end
   endtask

   // Monitor: fixed intra-cycle order matches the order events are pushed
   always @(negedge Clk) begin
      if (Rst) begin
         if (rxIf.Rx_NewByte)     checkEv(KByte, rxIf.Rx_Data);
         if (rxIf.Rx_FlagDetect)  checkEv(KFlag, 8'h00);
         if (rxIf.Rx_EoF)         checkEv(KEof, rxIf.Rx_FrameSize);
         if (rxIf.Rx_FrameError)  checkEv(KErr, 8'h00);
         if (rxIf.Rx_AbortDetect) checkEv(KAbort, 8'h00);
      end
   end

   task automatic send_bit(input logic b);
      @(negedge Clk);
      rxIf.Rx   = b;
      rxIf.RxEN = 1'b1;
      if (gapMode) begin
         @(negedge Clk);
         rxIf.RxEN = 1'b0;
         rxIf.Rx   = 1'($urandom_range(0, 1));
      end
   endtask

   // Sends v[0] first
   task automatic send_raw(input logic [15:0] v, input int n);
      for (int i = 0; i < n; i++) send_bit(v[i]);
   endtask

   task automatic send_byte(input logic [7:0] b);
      send_raw({8'h00, b}, 8);
   endtask

   task automatic send_flag();
      send_raw(16'h007E, 8);
   endtask

   task automatic drain(input int n);
      @(negedge Clk);
      rxIf.RxEN = 1'b0;
      repeat (n) @(negedge Clk);
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      gapMode   = 1'b0;
      Rst       = 1'b0;
      rxIf.Rx   = 1'b1;
      rxIf.RxEN = 1'b0;
      #12;
      checkVal("reset_valid", 32'(rxIf.Rx_ValidFrame), 32'd0);
      checkVal("reset_data", 32'(rxIf.Rx_Data), 32'd0);
      checkVal("reset_size", 32'(rxIf.Rx_FrameSize), 32'd0);
      checkVal("reset_pulses", 32'({rxIf.Rx_FlagDetect, rxIf.Rx_AbortDetect, rxIf.Rx_NewByte,
                                    rxIf.Rx_EoF, rxIf.Rx_FrameError}), 32'd0);
      @(negedge Clk);
      Rst = 1'b1;

      // Idle ones, opening flag, idle flag, 0x12 0x34, closing flag
      send_raw(16'h00FF, 8);
      expect_ev(KFlag, 8'h00, 1'b1); send_flag();
      expect_ev(KFlag, 8'h00, 1'b1); send_flag();
      expect_ev(KByte, 8'h12, 1'b1); send_byte(8'h12);
      expect_ev(KByte, 8'h34, 1'b1); send_byte(8'h34);
      expect_ev(KFlag, 8'h00, 1'b1); expect_ev(KEof, 8'd2, 1'b1); send_flag();
      drain(3);
      checkVal("t1_valid_after_close", 32'(rxIf.Rx_ValidFrame), 32'd1);

      // Stuffed 0xFF and 0x7E
      expect_ev(KFlag, 8'h00, 1'b1); send_flag();
      expect_ev(KByte, 8'hFF, 1'b1); send_raw(16'h01DF, 9);
      expect_ev(KByte, 8'h7E, 1'b1); send_raw(16'h00BE, 9);
      expect_ev(KFlag, 8'h00, 1'b1); expect_ev(KEof, 8'd2, 1'b1); send_flag();
      drain(3);
      checkVal("t2_data", 32'(rxIf.Rx_Data), 32'h7E);

      // Abort after 0xA5, then a clean two-byte frame
      expect_ev(KFlag, 8'h00, 1'b1); send_flag();
      send_byte(8'hA5);
      expect_ev(KAbort, 8'h00, 1'b0); send_raw(16'h00FF, 8);
      drain(3);
      checkVal("t3_valid_after_abort", 32'(rxIf.Rx_ValidFrame), 32'd0);
      expect_ev(KFlag, 8'h00, 1'b1); send_flag();
      expect_ev(KByte, 8'h01, 1'b1); send_byte(8'h01);
      expect_ev(KByte, 8'h02, 1'b1); send_byte(8'h02);
      expect_ev(KFlag, 8'h00, 1'b1); expect_ev(KEof, 8'd2, 1'b1); send_flag();
      drain(3);

      // 0xA5 plus 3 pending bits at close
      expect_ev(KFlag, 8'h00, 1'b1); send_flag();
      expect_ev(KByte, 8'hA5, 1'b1); send_byte(8'hA5);
      send_raw(16'h0005, 3);
      expect_ev(KFlag, 8'h00, 1'b1); expect_ev(KErr, 8'h00, 1'b1); send_flag();
      drain(3);
      checkVal("t4_valid_after_err", 32'(rxIf.Rx_ValidFrame), 32'd1);
      checkVal("t4_size_held", 32'(rxIf.Rx_FrameSize), 32'd2);

      // Overflow with MAX_BYTES=4; zeros flush the fifth byte out
      expect_ev(KFlag, 8'h00, 1'b1); send_flag();
      expect_ev(KByte, 8'h11, 1'b1); send_byte(8'h11);
      expect_ev(KByte, 8'h22, 1'b1); send_byte(8'h22);
      expect_ev(KByte, 8'h33, 1'b1); send_byte(8'h33);
      expect_ev(KByte, 8'h44, 1'b1); send_byte(8'h44);
      expect_ev(KErr, 8'h00, 1'b0); send_byte(8'h55);
      send_raw(16'h0000, 8);
      drain(3);
      checkVal("t5_valid_after_ovf", 32'(rxIf.Rx_ValidFrame), 32'd0);
      checkVal("t5_data_held", 32'(rxIf.Rx_Data), 32'h44);

      // First frame again with RxEN low every other cycle
      gapMode = 1'b1;
      send_raw(16'h00FF, 8);
      expect_ev(KFlag, 8'h00, 1'b1); send_flag();
      expect_ev(KFlag, 8'h00, 1'b1); send_flag();
      expect_ev(KByte, 8'h12, 1'b1); send_byte(8'h12);
      expect_ev(KByte, 8'h34, 1'b1); send_byte(8'h34);
      expect_ev(KFlag, 8'h00, 1'b1); expect_ev(KEof, 8'd2, 1'b1); send_flag();
      gapMode = 1'b0;
      drain(3);

      // Reset mid-byte, then data without a flag is ignored
      expect_ev(KFlag, 8'h00, 1'b1); send_flag();
      send_raw(16'h0002, 4);
      drain(2);
      @(posedge Clk);
      #2 Rst = 1'b0;
      #1;
      checkVal("rst_mid_valid", 32'(rxIf.Rx_ValidFrame), 32'd0);
      checkVal("rst_mid_outputs", {8'h00, rxIf.Rx_Data, rxIf.Rx_FrameSize,
               3'b000, rxIf.Rx_FlagDetect, rxIf.Rx_AbortDetect, rxIf.Rx_NewByte,
               rxIf.Rx_EoF, rxIf.Rx_FrameError}, 32'd0);
      @(negedge Clk);
      @(negedge Clk);
      Rst = 1'b1;
      send_byte(8'h12);
      send_byte(8'h34);
      send_byte(8'h56);
      expect_ev(KFlag, 8'h00, 1'b1); send_flag();
      expect_ev(KByte, 8'h55, 1'b1); send_byte(8'h55);
      expect_ev(KByte, 8'hAA, 1'b1); send_byte(8'hAA);
      expect_ev(KFlag, 8'h00, 1'b1); expect_ev(KEof, 8'd2, 1'b1); send_flag();
      drain(4);

      checkVal("pending_events", 32'(expQ.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
